// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared pixel type, pixel limits and stats FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    typedef logic [7:0] pixel_t;

    localparam pixel_t PIX_MIN = 8'd0;
    localparam pixel_t PIX_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } stats_state_e;

endpackage
`default_nettype wire

// File: rtl/img_frame_stats_if.sv
`default_nettype none
// ============================================================================
//  Module      : img_frame_stats_if
//  Description : Pixel input stream, threshold/clear control and result port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface img_frame_stats_if #(
    parameter int CNT_W = 17,
    parameter int SUM_W = 25
) ();
    import img_pkg::*;

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    pixel_t           in_byte;
    pixel_t           threshold;
    logic             stat_valid;
    logic             stat_ready;
    pixel_t           stat_min;
    pixel_t           stat_max;
    logic [SUM_W-1:0] stat_sum;
    logic [CNT_W-1:0] stat_above;

    modport master (
        output clear, in_valid, in_byte, threshold, stat_ready,
        input  in_ready, stat_valid, stat_min, stat_max, stat_sum, stat_above
    );

    modport slave (
        input  clear, in_valid, in_byte, threshold, stat_ready,
        output in_ready, stat_valid, stat_min, stat_max, stat_sum, stat_above
    );

endinterface
`default_nettype wire

// File: rtl/img_stats_acc.sv
`default_nettype none
// ============================================================================
//  Module      : img_stats_acc
//  Description : Running min/max/sum/above/count accumulators for one frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_stats_acc
    import img_pkg::*;
#(
    parameter int FRAME_PIXELS = 98304,
    parameter int CNT_W        = $clog2(FRAME_PIXELS + 1),
    parameter int SUM_W        = CNT_W + 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             init,
    input  wire logic             update,
    input  wire pixel_t           pixel,
    input  wire pixel_t           threshold,
    output logic                  last,
    output pixel_t                min_nxt,
    output pixel_t                max_nxt,
    output logic [SUM_W-1:0]      sum_nxt,
    output logic [CNT_W-1:0]      above_nxt
);

    pixel_t           r_thr;
    pixel_t           r_min;
    pixel_t           r_max;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_above;
    logic [CNT_W-1:0] r_cnt;

    pixel_t           w_thr;
    logic             w_hit;
    logic             w_step;
    logic [CNT_W-1:0] w_cnt_nxt;

    // The first pixel compares against the live threshold, later ones against the latched copy
    assign w_thr     = init ? threshold : r_thr;
    assign w_hit     = (pixel >= w_thr);
    assign w_step    = init || update;

    assign min_nxt   = (init || (pixel < r_min)) ? pixel : r_min;
    assign max_nxt   = (init || (pixel > r_max)) ? pixel : r_max;
    assign sum_nxt   = (init ? '0 : r_sum)   + SUM_W'(pixel);
    assign above_nxt = (init ? '0 : r_above) + CNT_W'(w_hit);
    assign w_cnt_nxt = (init ? '0 : r_cnt)   + CNT_W'(1);
    assign last      = w_step && (w_cnt_nxt == CNT_W'(FRAME_PIXELS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr   <= PIX_MIN;
            r_min   <= PIX_MIN;
            r_max   <= PIX_MIN;
            r_sum   <= '0;
            r_above <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            if (init) begin
                r_thr <= threshold;
            end
            r_min   <= min_nxt;
            r_max   <= max_nxt;
            r_sum   <= sum_nxt;
            r_above <= above_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/img_frame_stats.sv
`default_nettype none
// ============================================================================
//  Module      : img_frame_stats
//  Description : Per-frame pixel statistics with a held, handshaked result.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_frame_stats
    import img_pkg::*;
#(
    parameter int FRAME_PIXELS = 98304
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    img_frame_stats_if.slave   bus
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam int SUM_W = CNT_W + 8;

    stats_state_e     r_state;
    stats_state_e     w_state_nxt;

    logic             w_accept;
    logic             w_init;
    logic             w_update;
    logic             w_last;
    pixel_t           w_min_nxt;
    pixel_t           w_max_nxt;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [CNT_W-1:0] w_above_nxt;

    pixel_t           r_min;
    pixel_t           r_max;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_above;

    assign bus.in_ready   = (r_state != REPORT);
    assign bus.stat_valid = (r_state == REPORT);
    assign bus.stat_min   = r_min;
    assign bus.stat_max   = r_max;
    assign bus.stat_sum   = r_sum;
    assign bus.stat_above = r_above;

    assign w_accept = bus.in_valid && (r_state != REPORT);
    assign w_init   = w_accept && !bus.clear && (r_state == IDLE);
    assign w_update = w_accept && !bus.clear && (r_state == ACCUM);

    img_stats_acc #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .CNT_W        (CNT_W),
        .SUM_W        (SUM_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (w_init),
        .update    (w_update),
        .pixel     (bus.in_byte),
        .threshold (bus.threshold),
        .last      (w_last),
        .min_nxt   (w_min_nxt),
        .max_nxt   (w_max_nxt),
        .sum_nxt   (w_sum_nxt),
        .above_nxt (w_above_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_init)         w_state_nxt = w_last ? REPORT : ACCUM;
                ACCUM:   if (w_last)         w_state_nxt = REPORT;
                REPORT:  if (bus.stat_ready) w_state_nxt = IDLE;
                default:                     w_state_nxt = IDLE;
            endcase
        end
    end

    // Results load on the final accept so they are visible as stat_valid rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min   <= PIX_MIN;
            r_max   <= PIX_MIN;
            r_sum   <= '0;
            r_above <= '0;
        end else if (w_last) begin
            r_min   <= w_min_nxt;
            r_max   <= w_max_nxt;
            r_sum   <= w_sum_nxt;
            r_above <= w_above_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_frame_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_frame_stats
//  Description : Directed and randomized checks of img_frame_stats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_frame_stats;
    import img_pkg::*;

    localparam int FP_A = 4;
    localparam int FP_B = 1;
    localparam int FP_C = 4096;
    localparam int CW_A = $clog2(FP_A + 1);
    localparam int CW_B = $clog2(FP_B + 1);
    localparam int CW_C = $clog2(FP_C + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    img_frame_stats_if #(.CNT_W(CW_A), .SUM_W(CW_A + 8)) a ();
    img_frame_stats_if #(.CNT_W(CW_B), .SUM_W(CW_B + 8)) b ();
    img_frame_stats_if #(.CNT_W(CW_C), .SUM_W(CW_C + 8)) c ();

    img_frame_stats #(.FRAME_PIXELS(FP_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    img_frame_stats #(.FRAME_PIXELS(FP_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    img_frame_stats #(.FRAME_PIXELS(FP_C)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c.slave));

    int     vecs        = 0;
    int     miscompares = 0;
    pixel_t frame_q[$];
    pixel_t thr_first;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one pixel on bus a after 'gap' idle cycles; returns just after the accepting edge
    task automatic push(input pixel_t px, input pixel_t thr, input int gap);
        int bound;
        a.in_valid = 1'b0;
        repeat (gap) tick();
        a.in_valid  = 1'b1;
        a.in_byte   = px;
        a.threshold = thr;
        bound = 0;
        while (!a.in_ready && bound < 50) begin
            tick();
            bound++;
        end
        chk("push_ready", {31'd0, a.in_ready}, 32'd1);
        if (frame_q.size() == 0) thr_first = thr;
        frame_q.push_back(px);
        tick();
        a.in_valid = 1'b0;
    endtask

    // Reference: statistics recomputed from the list of accepted pixels
    task automatic check_frame(input string tag);
        int mn = 255;
        int mx = 0;
        int sm = 0;
        int ab = 0;
        foreach (frame_q[i]) begin
            if (int'(frame_q[i]) < mn) mn = int'(frame_q[i]);
            if (int'(frame_q[i]) > mx) mx = int'(frame_q[i]);
            sm += int'(frame_q[i]);
            if (frame_q[i] >= thr_first) ab++;
        end
        chk({tag, "_valid"}, {31'd0, a.stat_valid}, 32'd1);
        chk({tag, "_min"},   32'(a.stat_min),   32'(mn));
        chk({tag, "_max"},   32'(a.stat_max),   32'(mx));
        chk({tag, "_sum"},   32'(a.stat_sum),   32'(sm));
        chk({tag, "_above"}, 32'(a.stat_above), 32'(ab));
        frame_q.delete();
    endtask

    task automatic accept_result();
        a.stat_ready = 1'b1;
        tick();
        a.stat_ready = 1'b0;
        chk("hs_valid_low", {31'd0, a.stat_valid}, 32'd0);
        chk("hs_ready_back", {31'd0, a.in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_sum;
        pixel_t      px;
        pixel_t      th;
        int          n;

        a.clear = 1'b0; a.in_valid = 1'b0; a.in_byte = '0; a.threshold = '0; a.stat_ready = 1'b0;
        b.clear = 1'b0; b.in_valid = 1'b0; b.in_byte = '0; b.threshold = '0; b.stat_ready = 1'b0;
        c.clear = 1'b0; c.in_valid = 1'b0; c.in_byte = '0; c.threshold = '0; c.stat_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, a.in_ready}, 32'd1);
        chk("rst_valid",    {31'd0, a.stat_valid}, 32'd0);
        chk("rst_min",      32'(a.stat_min), 32'd0);
        chk("rst_max",      32'(a.stat_max), 32'd0);
        chk("rst_sum",      32'(a.stat_sum), 32'd0);
        chk("rst_above",    32'(a.stat_above), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, back-to-back
        push(8'd10, 8'd160, 0);
        push(8'd200, 8'd160, 0);
        push(8'd0, 8'd160, 0);
        push(8'd255, 8'd160, 0);
        chk("basic_sum_const",   32'(a.stat_sum), 32'd465);
        chk("basic_above_const", 32'(a.stat_above), 32'd2);
        check_frame("basic");
        accept_result();

        // Backpressure while a new pixel waits
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        check_frame("bp_frame");
        prev_sum     = 32'(a.stat_sum);
        a.in_valid   = 1'b1;
        a.in_byte    = 8'd77;
        a.threshold  = 8'd5;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", {31'd0, a.in_ready}, 32'd0);
            chk("bp_valid",    {31'd0, a.stat_valid}, 32'd1);
            chk("bp_sum_hold", 32'(a.stat_sum), prev_sum);
        end
        accept_result();
        push(8'd77, 8'd5, 0);
        for (int k = 0; k < 3; k++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        check_frame("bp_next");
        accept_result();

        // Bubbles and mid-frame threshold change
        push(8'd20, 8'd30, $urandom_range(0, 3));
        push(8'd30, 8'd30, $urandom_range(0, 3));
        push(8'd40, 8'd0, $urandom_range(0, 3));
        push(8'd50, 8'd0, $urandom_range(0, 3));
        chk("bub_above_const", 32'(a.stat_above), 32'd3);
        chk("bub_sum_const",   32'(a.stat_sum), 32'd140);
        check_frame("bubbles");
        accept_result();

        // Clear mid-frame, then clear in REPORT
        push(8'd99, 8'd0, 0);
        push(8'd99, 8'd0, 0);
        a.clear = 1'b1;
        tick();
        a.clear = 1'b0;
        frame_q.delete();
        chk("clr_valid",    {31'd0, a.stat_valid}, 32'd0);
        chk("clr_in_ready", {31'd0, a.in_ready}, 32'd1);
        for (int k = 1; k <= 4; k++) push(8'(k), 8'($urandom_range(0, 255)), 0);
        chk("clr_sum_const", 32'(a.stat_sum), 32'd10);
        chk("clr_max_const", 32'(a.stat_max), 32'd4);
        check_frame("clear");
        a.clear = 1'b1;
        tick();
        a.clear = 1'b0;
        chk("clr_rep_valid", {31'd0, a.stat_valid}, 32'd0);
        chk("clr_rep_sum",   32'(a.stat_sum), 32'd10);

        // Randomized frames with gaps, threshold changes and result stalls
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 4; k++) begin
                n  = $urandom_range(0, 9);
                px = (n == 0) ? 8'd0 : (n == 1) ? 8'd255 : 8'($urandom_range(0, 255));
                push(px, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
            end
            check_frame("rand");
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rand_hold", {31'd0, a.stat_valid}, 32'd1);
            end
            accept_result();
        end

        // Asynchronous reset while a result is held
        for (int k = 0; k < 4; k++) push(8'($urandom_range(1, 255)), 8'd0, 0);
        frame_q.delete();
        chk("arst_pre_valid", {31'd0, a.stat_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, a.stat_valid}, 32'd0);
        chk("arst_sum",   32'(a.stat_sum), 32'd0);
        chk("arst_min",   32'(a.stat_min), 32'd0);
        chk("arst_max",   32'(a.stat_max), 32'd0);
        chk("arst_above", 32'(a.stat_above), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("arst_in_ready", {31'd0, a.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        check_frame("arst_next");
        accept_result();

        // Single-pixel frames
        for (int k = 0; k < 6; k++) begin
            px = (k == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            th = (k == 1) ? px : 8'($urandom_range(0, 255));
            b.in_valid  = 1'b1;
            b.in_byte   = px;
            b.threshold = th;
            chk("one_in_ready", {31'd0, b.in_ready}, 32'd1);
            tick();
            b.in_valid = 1'b0;
            chk("one_valid", {31'd0, b.stat_valid}, 32'd1);
            chk("one_min",   32'(b.stat_min), 32'(px));
            chk("one_max",   32'(b.stat_max), 32'(px));
            chk("one_sum",   32'(b.stat_sum), 32'(px));
            chk("one_above", 32'(b.stat_above), (px >= th) ? 32'd1 : 32'd0);
            b.stat_ready = 1'b1;
            tick();
            b.stat_ready = 1'b0;
            chk("one_back", {31'd0, b.in_ready}, 32'd1);
        end

        // Large saturated frame
        c.in_valid  = 1'b1;
        c.in_byte   = 8'd255;
        c.threshold = 8'd255;
        n = 0;
        while (!c.stat_valid && n < 5000) begin
            tick();
            n++;
        end
        c.in_valid = 1'b0;
        chk("big_cycles", 32'(n), 32'(FP_C));
        chk("big_sum",    32'(c.stat_sum), 32'(FP_C * 255));
        chk("big_above",  32'(c.stat_above), 32'(FP_C));
        chk("big_min",    32'(c.stat_min), 32'd255);
        chk("big_max",    32'(c.stat_max), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
